// File: rtl/result_sequencer.sv
// result_sequencer: snapshots eight 8-bit results and presents them one at a
// time on a 1 Hz clock, HOLD_SEC periods each, with BCD of the shown value.
// Ports: clk_1hz, resetn (async, active-low); data_in[63:0] (entry k at
// [8k+7:8k]), load, start, pause in; value[7:0], bcd[11:0], idx[2:0], group,
// valid, busy, done, load_ignored out (all registered).
// Build option: define RESULT_SEQ_LOOP_EN to wrap from entry 7 back to 0.
module result_sequencer #(
    parameter int HOLD_SEC = 1
) (
    input  logic        clk_1hz,
    input  logic        resetn,
    input  logic [63:0] data_in,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    output logic [7:0]  value,
    output logic [11:0] bcd,
    output logic [2:0]  idx,
    output logic        group,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        load_ignored
);

    typedef enum logic [1:0] {IDLE, LOADED, SHOW, DONE} state_t;

`ifdef RESULT_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_SEC - 1);

    state_t      state_q, state_d;
    logic [63:0] snap_q, snap_d;
    logic [3:0]  hold_q, hold_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  value_q, value_d;
    logic [11:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        li_q, li_d;

    logic [2:0]  next_idx;
    logic [7:0]  next_val;

    // Double-dabble: exact for 0..255
    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        logic [19:0] s;
        s = {12'd0, v};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8] >= 4'd5)  s[11:8]  = s[11:8] + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return s[19:8];
    endfunction

    // Wraps 7 -> 0 naturally, which is what the loop build wants
    assign next_idx = idx_q + 3'd1;
    assign next_val = snap_q[{next_idx, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        value_d = value_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        li_d    = 1'b0;
        unique case (state_q)
            IDLE, LOADED, DONE: begin
                if (load) begin
                    // load wins over start; start must be re-asserted
                    snap_d  = data_in;
                    state_d = LOADED;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (state_q == LOADED && start) begin
                    state_d = SHOW;
                    hold_d  = 4'd0;
                    idx_d   = 3'd0;
                    value_d = snap_q[7:0];
                    bcd_d   = to_bcd(snap_q[7:0]);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHOW: begin
                li_d = load;
                if (!pause) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = 4'd0;
                        if (idx_q == 3'd7 && !LOOP_EN) begin
                            // value/bcd/idx keep entry 7
                            state_d = DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = next_idx;
                            value_d = next_val;
                            bcd_d   = to_bcd(next_val);
                        end
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1hz or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            snap_q  <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            value_q <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            li_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            li_q    <= li_d;
        end
    end

    assign value        = value_q;
    assign bcd          = bcd_q;
    assign idx          = idx_q;
    assign group        = idx_q[2];
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign load_ignored = li_q;

endmodule

// File: tb/tb_result_sequencer.sv
// tb_result_sequencer: scoreboard bench for result_sequencer, one instance
// with HOLD_SEC=1 and one with HOLD_SEC=3.
module tb_result_sequencer;

    logic clk_1hz = 1'b0;
    logic resetn  = 1'b1;

    logic [63:0] d1, d3;
    logic        ld1, st1, ps1, ld3, st3, ps3;
    logic [7:0]  v1, v3;
    logic [11:0] b1, b3;
    logic [2:0]  i1, i3;
    logic        g1, g3, vl1, vl3, bs1, bs3, dn1, dn3, li1, li3;

    always #5 clk_1hz = ~clk_1hz;

    result_sequencer #(.HOLD_SEC(1)) u1 (
        .clk_1hz(clk_1hz), .resetn(resetn), .data_in(d1),
        .load(ld1), .start(st1), .pause(ps1),
        .value(v1), .bcd(b1), .idx(i1), .group(g1),
        .valid(vl1), .busy(bs1), .done(dn1), .load_ignored(li1)
    );

    result_sequencer #(.HOLD_SEC(3)) u3 (
        .clk_1hz(clk_1hz), .resetn(resetn), .data_in(d3),
        .load(ld3), .start(st3), .pause(ps3),
        .value(v3), .bcd(b3), .idx(i3), .group(g3),
        .valid(vl3), .busy(bs3), .done(dn3), .load_ignored(li3)
    );

    typedef struct {
        bit          sel;
        logic [27:0] e;
        string       tag;
    } item_t;

    item_t sb[$];
    item_t cur;
    int    checks = 0;
    int    errors = 0;

    logic [7:0]  va [8];
    logic [11:0] ba [8];
    logic [7:0]  vc [8];
    logic [11:0] bc [8];
    logic [63:0] data_a, data_c;
    logic [63:0] data_b = 64'h1111_2222_3333_4444;
    logic [63:0] data_d = 64'hAAAA_AAAA_AAAA_AAAA;

    // {valid, busy, done, load_ignored, group, idx, value, bcd}
    function automatic logic [27:0] ex(bit v, bit b, bit dn, bit li,
                                       logic [2:0] i, logic [7:0] val,
                                       logic [11:0] bd);
        return {v, b, dn, li, i[2], i, val, bd};
    endfunction

    function automatic logic [27:0] act(bit sel);
        if (sel)
            return {vl3, bs3, dn3, li3, g3, i3, v3, b3};
        return {vl1, bs1, dn1, li1, g1, i1, v1, b1};
    endfunction

    task automatic check(string tag, logic [27:0] a, logic [27:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, a, e);
        end
    endtask

    task automatic step(bit sel, bit ld, bit st, bit ps, logic [63:0] d,
                        logic [27:0] e, string tag);
        item_t it;
        @(negedge clk_1hz);
        ld1 = 1'b0; st1 = 1'b0; ps1 = 1'b0; d1 = '0;
        ld3 = 1'b0; st3 = 1'b0; ps3 = 1'b0; d3 = '0;
        if (sel) begin
            ld3 = ld; st3 = st; ps3 = ps; d3 = d;
        end else begin
            ld1 = ld; st1 = st; ps1 = ps; d1 = d;
        end
        it.sel = sel;
        it.e   = e;
        it.tag = tag;
        sb.push_back(it);
        @(posedge clk_1hz);
    endtask

    // Monitor: compares one queued expectation per clock edge
    always @(posedge clk_1hz) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check(cur.tag, act(cur.sel), cur.e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [27:0] z;
        logic [27:0] last;
        int extra;
        z = ex(0, 0, 0, 0, 3'd0, 8'd0, 12'h000);
        va = '{8'd0, 8'd9, 8'd99, 8'd100, 8'd128, 8'd200, 8'd254, 8'd255};
        ba = '{12'h000, 12'h009, 12'h099, 12'h100,
               12'h128, 12'h200, 12'h254, 12'h255};
        vc = '{8'd3, 8'd17, 8'd42, 8'd63, 8'd77, 8'd150, 8'd201, 8'd230};
        bc = '{12'h003, 12'h017, 12'h042, 12'h063,
               12'h077, 12'h150, 12'h201, 12'h230};
        for (int i = 0; i < 8; i++) begin
            data_a[8*i +: 8] = va[i];
            data_c[8*i +: 8] = vc[i];
        end
        ld1 = 0; st1 = 0; ps1 = 0; d1 = '0;
        ld3 = 0; st3 = 0; ps3 = 0; d3 = '0;

        #2 resetn = 1'b0;
        #1;
        check("reset_u1", act(0), z);
        check("reset_u3", act(1), z);
        @(negedge clk_1hz);
        resetn = 1'b1;

        step(0, 0, 1, 0, '0, z, "idle_start");
        step(0, 1, 0, 0, data_a, z, "load_a");
        step(0, 0, 1, 0, '0, ex(1, 1, 0, 0, 3'd0, va[0], ba[0]), "show0");
`ifdef RESULT_SEQ_LOOP_EN
        for (int n = 1; n <= 20; n++)
            step(0, 0, 0, 0, '0,
                 ex(1, 1, 0, 0, 3'(n % 8), va[n % 8], ba[n % 8]), "loop");
`else
        for (int k = 1; k < 8; k++)
            step(0, 0, 0, 0, '0,
                 ex(1, 1, 0, 0, 3'(k), va[k], ba[k]), "show_a");
        last = ex(0, 0, 1, 0, 3'd7, 8'd255, 12'h255);
        step(0, 0, 0, 0, '0, last, "done9");
        step(0, 0, 1, 0, '0, last, "done_start");

        // DONE -> LOADED retains last entry on value/bcd/idx
        last = ex(0, 0, 0, 0, 3'd7, 8'd255, 12'h255);
        step(0, 1, 0, 0, data_b, last, "load_b");
        step(0, 1, 1, 0, data_c, last, "load_start_same");
        step(0, 0, 1, 0, '0, ex(1, 1, 0, 0, 3'd0, vc[0], bc[0]), "c0");
        step(0, 0, 0, 0, '0, ex(1, 1, 0, 0, 3'd1, vc[1], bc[1]), "c1");
        step(0, 0, 0, 0, '0, ex(1, 1, 0, 0, 3'd2, vc[2], bc[2]), "c2");
        step(0, 1, 0, 0, data_d, ex(1, 1, 0, 1, 3'd3, vc[3], bc[3]),
             "ignored_load");
        for (int k = 4; k < 8; k++)
            step(0, 0, 0, 0, '0,
                 ex(1, 1, 0, 0, 3'(k), vc[k], bc[k]), "show_c");
        step(0, 0, 0, 0, '0, ex(0, 0, 1, 0, 3'd7, vc[7], bc[7]), "done_c");

        // Reset in the middle of SHOW
        step(0, 1, 0, 0, data_a, ex(0, 0, 0, 0, 3'd7, vc[7], bc[7]),
             "reload_a");
        step(0, 0, 1, 0, '0, ex(1, 1, 0, 0, 3'd0, va[0], ba[0]), "r0");
        for (int k = 1; k <= 5; k++)
            step(0, 0, 0, 0, '0,
                 ex(1, 1, 0, 0, 3'(k), va[k], ba[k]), "r_show");
        @(negedge clk_1hz);
        resetn = 1'b0;
        #1;
        check("async_reset", act(0), z);
        @(negedge clk_1hz);
        resetn = 1'b1;
        step(0, 0, 1, 0, '0, z, "post_reset_start");
        step(0, 0, 1, 0, '0, z, "post_reset_start2");

        // HOLD_SEC=3 with a 2-edge pause during entry 4
        step(1, 1, 0, 0, data_a, z, "h3_load");
        step(1, 0, 1, 0, '0, ex(1, 1, 0, 0, 3'd0, va[0], ba[0]), "h3_0");
        for (int k = 0; k < 8; k++) begin
            extra = (k == 4) ? 4 : 2;
            for (int n = 1; n <= extra; n++)
                step(1, 0, 0, (k == 4 && n <= 2), '0,
                     ex(1, 1, 0, 0, 3'(k), va[k], ba[k]), "h3_hold");
            if (k < 7)
                step(1, 0, 0, 0, '0,
                     ex(1, 1, 0, 0, 3'(k + 1), va[k + 1], ba[k + 1]),
                     "h3_adv");
            else
                step(1, 0, 0, 0, '0,
                     ex(0, 0, 1, 0, 3'd7, va[7], ba[7]), "h3_done");
        end
`endif
        @(negedge clk_1hz);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/result_sequencer.md
RESULT_SEQUENCER -- requirements
Module: result_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_SEC, default 1, legal range 1..15, setting the number of clk_1hz periods each entry is presented.
REQ-002 The block SHALL have port clk_1hz, input, 1 bit: the 1 Hz sequencing clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_in, input, 64 bits: eight packed 8-bit results, with entry k at bits [8k+7:8k]; order is c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22 for k=0..7.
REQ-005 The block SHALL have port load, input, 1 bit: snapshot request, level-sampled at each clk_1hz edge.
REQ-006 The block SHALL have port start, input, 1 bit: begin-presentation request, level-sampled.
REQ-007 The block SHALL have port pause, input, 1 bit: while high in SHOW, the current entry is frozen.
REQ-008 The block SHALL have port value, output, 8 bits: the currently presented entry.
REQ-009 The block SHALL have port bcd, output, 12 bits: value as hundreds [11:8], tens [7:4], ones [3:0].
REQ-010 The block SHALL have port idx, output, 3 bits: index of the presented entry; port group, output, 1 bit, equals idx[2] (0 = c9 set, 1 = c4 set).
REQ-011 The block SHALL have port valid, output, 1 bit: high only in SHOW.
REQ-012 The block SHALL have ports busy, done and load_ignored, each output, 1 bit.

Function
REQ-013 The block SHALL implement states IDLE, LOADED, SHOW and DONE; busy SHALL be high exactly in SHOW, and done exactly in DONE.
REQ-014 In IDLE, LOADED or DONE, load=1 SHALL copy data_in into the 8x8 internal buffer at that edge and move the block to LOADED.
REQ-015 load SHALL take priority over start on the same edge; start is then ignored and must be re-asserted.
REQ-016 In LOADED, start=1 with load=0 SHALL enter SHOW at that edge with idx=0, value=buf[0], valid=1 and the hold counter cleared.
REQ-017 In SHOW with pause=0, the hold counter SHALL increment each edge; after HOLD_SEC edges on one entry, idx SHALL advance by 1 and value/bcd SHALL update on the same edge.
REQ-018 In SHOW with pause=1, idx, value, bcd and the hold counter SHALL all hold.
REQ-019 When the HOLD_SEC period of entry 7 completes, the block SHALL enter DONE with valid=0, and value, bcd and idx SHALL retain entry 7.
REQ-020 In SHOW, load=1 SHALL be ignored, leaving buffer and sequence unchanged, and load_ignored SHALL pulse high for exactly one clk_1hz period; start in SHOW or DONE SHALL be ignored.
REQ-021 bcd SHALL be registered together with value so both change on the same edge; conversion SHALL be exact for 0..255 (e.g. 0xFF gives 12'h255).
REQ-022 start in IDLE (buffer never loaded) SHALL have no effect.

Reset
REQ-023 resetn=0 SHALL immediately, regardless of clock, force state IDLE, clear the buffer and hold counter to 0, and drive value, bcd, idx, group, valid, busy, done and load_ignored to 0.
REQ-024 Reset asserted mid-SHOW SHALL abort the sequence; after release, a new load is required.

Configuration
REQ-025 Macro RESULT_SEQ_LOOP_EN: when defined, completion of entry 7 in SHOW SHALL wrap idx to 0 (value=buf[0]) and remain in SHOW, with done never asserting; when undefined, REQ-019 applies.

Verification
REQ-026 Reset, then load entries {0,9,99,100,128,200,254,255} and start with HOLD_SEC=1: idx 0..7 over 8 edges, bcd 12'h000 to 12'h255, done=1 on the 9th edge.
REQ-027 HOLD_SEC=3: each idx lasts 3 edges; pause high for 2 edges during idx 4 extends idx 4 to 5 edges.
REQ-028 load with new data at idx 2 in SHOW: load_ignored pulses for one period and the original values continue.
REQ-029 load=1 and start=1 on the same edge in LOADED: state stays LOADED with the new buffer, valid=0.
REQ-030 resetn low at idx 5: all outputs 0 within the same cycle, state IDLE; start after release gives no response.
REQ-031 With RESULT_SEQ_LOOP_EN defined: entry 7 is followed by idx=0 and value=buf[0], and done stays 0 for 20 edges.
